instr_fetch_unit: RTL and testbench

- Fetch stage that directly feeds the branch/next-PC logic.
- Owns the architectural PC register and drives pc_out into the next-PC block's pc_in.
- Reads one word per instruction from word-addressed instruction memory over a req/valid handshake and holds the fetched word for decode with a valid/ready handshake.
- Loads the resolved next PC (pc_next, produced by the next-PC block) only when the execute side pulses pc_load; this serialises fetch and execute (no speculation).

---
 rtl/cpu_defs_pkg.sv | 39 +++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode field position,
// the halt opcode and the branch function codes used by decode and next-PC.
package cpu_defs_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        ISSUE      = 3'd2,
        EXEC       = 3'd3,
        HALTED     = 3'd4
    } fetch_state_e;

    // Opcode field position inside an instruction word
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    // Opcode that stops the fetch stage for good (until reset)
    localparam logic [OPCODE_W-1:0] OPC_HALT = 6'b111111;

    // Branch function codes shared by decode and next-PC logic
    localparam logic [OPCODE_W-1:0] FUNC_BEQ = 6'b000100;
    localparam logic [OPCODE_W-1:0] FUNC_BNE = 6'b000101;
    localparam logic [OPCODE_W-1:0] FUNC_BLT = 6'b000110;
    localparam logic [OPCODE_W-1:0] FUNC_BGE = 6'b000111;

    // Extract the opcode field from a 32-bit instruction word
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    // True for any of the four branch function codes
    function automatic logic is_branch(input logic [OPCODE_W-1:0] opc);
        return (opc == FUNC_BEQ) || (opc == FUNC_BNE) ||
               (opc == FUNC_BLT) || (opc == FUNC_BGE);
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Non-speculative fetch stage. Owns the architectural PC, fetches one word
// per instruction and holds it for decode until execute pulses pc_load.
//
// Handshakes:
//   imem:   imem_req is a one-cycle request for the word at imem_addr; the
//           memory answers with a single-cycle imem_valid/imem_rdata one or
//           more cycles later. imem_valid is only sampled in FETCH_WAIT.
//   decode: instr_valid/instr_out are held stable until a rising edge where
//           instr_valid && instr_ready are both high; that edge is the
//           transfer. Ready is only looked at while in ISSUE.
//
// After reset the FSM spends one cycle in FETCH_REQ with imem_req low to
// arm the request register, then raises imem_req for exactly one cycle.
// Entering FETCH_REQ from EXEC arms the request on the pc_load edge, so the
// pc_load -> instr_valid latency is two edges plus the memory latency.
module instr_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter int                  ADDR_W      = 32,
    parameter int                  INSTR_W     = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC    = {ADDR_W{1'b0}},
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = OPC_HALT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_next,
    input  logic               pc_load,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted,
    output logic [2:0]         state_dbg
);

    fetch_state_e state;

    // Memory always reads the instruction's own PC
    assign imem_addr = pc_out;
    assign state_dbg = state;

    // Fetch FSM with the PC and instruction registers kept alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_REQ;
            pc_out      <= RESET_PC;
            imem_req    <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else begin
                        imem_req <= 1'b0;
                        state    <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_valid) begin
                        instr_out   <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (instr_out[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (pc_load) begin
                        pc_out   <= pc_next;
                        imem_req <= 1'b1;
                        state    <= FETCH_REQ;
                    end
                end
                HALTED: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= FETCH_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a variable-latency memory model,
// expected queues for delivered instructions and memory requests, and
// monitors that pop and compare whenever the DUT presents an output.
module tb_instr_fetch_unit;
    import cpu_defs_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic        halted;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];   // {pc, instr} expected at each decode transfer
    logic [31:0] req_q[$];   // expected imem_addr at each request

    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_next     (pc_next),
        .pc_load     (pc_load),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .halted      (halted),
        .state_dbg   (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0001;
            32'h0000_0001: return 32'h0000_0002;
            32'h0000_0005: return 32'h1000_0003;   // BEQ opcode
            32'h0000_0008: return 32'h2000_0008;
            32'h0000_0040: return 32'hFC00_0000;   // halt
            32'hFFFF_FFFF: return 32'h3000_00FF;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: stale responses are kept deliberately, so a request cut
    // by reset still answers late
    always @(negedge clk) begin
        imem_valid = 1'b0;
        if (mem_cnt != 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(mem_addr);
            end
        end
        if (imem_req) begin
            mem_addr = imem_addr;
            mem_cnt  = mem_lat;
        end
    end

    // Request monitor
    always @(negedge clk) begin
        if (imem_req) begin
            if (req_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: addr %0h with no request expected", imem_addr);
            end else begin
                check("req_addr", {32'h0, imem_addr}, {32'h0, req_q.pop_front()});
            end
        end
    end

    // Decode-transfer monitor
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: pc %0h instr %0h", pc_out, instr_out);
            end else begin
                check("deliver_pc_instr", {pc_out, instr_out}, exp_q.pop_front());
            end
        end
    end

    // Wait (at negedges) for the FSM to reach a state, bounded
    task automatic wait_state(input fetch_state_e st, input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state_dbg == st) begin
                seen = 1;
                break;
            end
        end
        check(name, {63'h0, seen}, 64'h1);
    endtask

    // Pulse pc_load from a negedge through the following edge
    task automatic load_pc(input logic [31:0] addr, input bit expect_deliver);
        pc_next = addr;
        pc_load = 1'b1;
        req_q.push_back(addr);
        if (expect_deliver) exp_q.push_back({addr, mem_word(addr)});
        @(posedge clk);
        #1 pc_load = 1'b0;
    endtask

    initial begin
        int edges;
        rst         = 1'b1;
        pc_next     = '0;
        pc_load     = 1'b0;
        instr_ready = 1'b1;
        imem_valid  = 1'b0;
        imem_rdata  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc",     {32'h0, pc_out}, 64'h0);
        check("rst_req",    {63'h0, imem_req}, 64'h0);
        check("rst_valid",  {63'h0, instr_valid}, 64'h0);
        check("rst_instr",  {32'h0, instr_out}, 64'h0);
        check("rst_halted", {63'h0, halted}, 64'h0);
        check("rst_state",  {61'h0, state_dbg}, {61'h0, FETCH_REQ});
        req_q.push_back(32'h0);
        exp_q.push_back({32'h0, mem_word(32'h0)});
        @(posedge clk);
        #1 rst = 1'b0;

        // First instruction, then pc_load to 1 with latency measured
        wait_state(EXEC, "wait_exec_0");
        check("exec0_pc", {32'h0, pc_out}, 64'h0);
        load_pc(32'h1, 1);
        edges = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) break;
            @(posedge clk);
            edges++;
        end
        check("load_to_valid_edges", 64'(edges), 64'd3);
        check("pc_after_load_1", {32'h0, pc_out}, 64'h1);

        // Sequential to 5, then taken branch 5 -> 8
        wait_state(EXEC, "wait_exec_1");
        load_pc(32'h5, 1);
        wait_state(EXEC, "wait_exec_5");
        pc_next = 32'h8;
        repeat (3) @(negedge clk);
        check("branch_pc_held", {32'h0, pc_out}, 64'h5);
        load_pc(32'h8, 1);
        instr_ready = 1'b0;

        // Decode back-pressure with a spurious pc_load in ISSUE
        wait_state(ISSUE, "wait_issue_8");
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                pc_next = 32'h77;
                pc_load = 1'b1;
            end else begin
                pc_load = 1'b0;
            end
            @(negedge clk);
            check("bp_valid", {63'h0, instr_valid}, 64'h1);
            check("bp_instr", {32'h0, instr_out}, {32'h0, mem_word(32'h8)});
            check("bp_no_req", {63'h0, imem_req}, 64'h0);
            check("bp_pc", {32'h0, pc_out}, 64'h8);
        end
        pc_load = 1'b0;
        @(posedge clk);
        #1 instr_ready = 1'b1;

        // Slow memory, top-of-space PC, spurious pc_load in FETCH_WAIT
        wait_state(EXEC, "wait_exec_8");
        mem_lat = 3;
        load_pc(32'hFFFF_FFFF, 1);
        wait_state(FETCH_WAIT, "wait_fw_top");
        pc_next = 32'h55;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        check("fw_spurious_pc", {32'h0, pc_out}, 64'hFFFF_FFFF);

        // Wrap to 0
        wait_state(EXEC, "wait_exec_top");
        mem_lat = 1;
        load_pc(32'h0, 1);
        @(negedge clk);
        check("wrap_pc", {32'h0, pc_out}, 64'h0);

        // Reset in FETCH_WAIT with a 3-cycle memory: late answer must be dropped
        wait_state(EXEC, "wait_exec_wrap");
        mem_lat = 3;
        load_pc(32'h8, 0);
        wait_state(FETCH_WAIT, "wait_fw_rst");
        rst = 1'b1;
        req_q.push_back(32'h0);
        exp_q.push_back({32'h0, mem_word(32'h0)});
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_pc",    {32'h0, pc_out}, 64'h0);
        check("midrst_valid", {63'h0, instr_valid}, 64'h0);
        check("midrst_state", {61'h0, state_dbg}, {61'h0, FETCH_REQ});

        // Halt instruction
        wait_state(EXEC, "wait_exec_after_rst");
        mem_lat = 1;
        load_pc(32'h40, 1);
        wait_state(HALTED, "wait_halted");
        check("halted_flag", {63'h0, halted}, 64'h1);
        for (int i = 0; i < 20; i++) begin
            pc_next = 32'h100 + 32'(i);
            pc_load = (i % 4 == 0);
            @(negedge clk);
            check("halt_no_req", {63'h0, imem_req}, 64'h0);
            check("halt_hold", {31'h0, halted, pc_out}, {31'h0, 1'b1, 32'h40});
        end
        pc_load = 1'b0;

        repeat (2) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("req_q_drained", 64'(req_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
